// File: rtl/fp_add_sequencer_if.sv
// Operand/result handshake bundle for fp_add_sequencer.
//   in_valid/in_ready   : operand-pair handshake (source -> sequencer)
//   in_exp_A/B          : unsigned operand exponents
//   in_mantissa_A/B     : two's-complement operand mantissas (MSB = sign)
//   out_valid/out_ready : result handshake (sequencer -> consumer)
//   out_exp/out_mantissa: result exponent / mantissa
//   out_ovf             : exponent overflow, result saturated
//   busy                : a transaction is in flight
// modport master: operand source + result consumer side.
// modport slave : the sequencer itself.
interface fp_add_sequencer_if #(
    parameter int MANTISSA = 11,
    parameter int EXPONENT = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [EXPONENT-1:0] in_exp_A;
    logic [MANTISSA-1:0] in_mantissa_A;
    logic [EXPONENT-1:0] in_exp_B;
    logic [MANTISSA-1:0] in_mantissa_B;
    logic                out_valid;
    logic                out_ready;
    logic [EXPONENT-1:0] out_exp;
    logic [MANTISSA-1:0] out_mantissa;
    logic                out_ovf;
    logic                busy;

    modport master (
        output in_valid, in_exp_A, in_mantissa_A, in_exp_B, in_mantissa_B, out_ready,
        input  in_ready, out_valid, out_exp, out_mantissa, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_exp_A, in_mantissa_A, in_exp_B, in_mantissa_B, out_ready,
        output in_ready, out_valid, out_exp, out_mantissa, out_ovf, busy
    );
endinterface

// File: rtl/fp_add_sequencer.sv
// Multi-cycle floating-point adder controller: value = mantissa * 2^exp, with a
// two's-complement mantissa and an unsigned exponent. One operand pair per
// transaction: align the smaller-exponent operand, add, normalize, present.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset (aborts any transaction in flight)
//   bus  : fp_add_sequencer_if.slave (operand/result handshakes, busy, out_ovf)
module fp_add_sequencer #(
    parameter int MANTISSA = 11,
    parameter int EXPONENT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_add_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    localparam logic [31:0] MAX_SHIFT = MANTISSA - 1;

    state_t              state, state_d;
    logic [MANTISSA-1:0] man_a, man_a_d, man_b, man_b_d;
    logic [EXPONENT-1:0] exp_a, exp_a_d, exp_b, exp_b_d;
    logic [MANTISSA-1:0] mant, mant_d;
    logic [EXPONENT-1:0] exp_r, exp_d;
    logic                ovf, ovf_d;
    logic [EXPONENT-1:0] diff;
    logic [31:0]         shamt;
    logic [MANTISSA:0]   sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            man_a <= '0;
            man_b <= '0;
            exp_a <= '0;
            exp_b <= '0;
            mant  <= '0;
            exp_r <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            man_a <= man_a_d;
            man_b <= man_b_d;
            exp_a <= exp_a_d;
            exp_b <= exp_b_d;
            mant  <= mant_d;
            exp_r <= exp_d;
            ovf   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state;
        man_a_d = man_a;
        man_b_d = man_b;
        exp_a_d = exp_a;
        exp_b_d = exp_b;
        mant_d  = mant;
        exp_d   = exp_r;
        ovf_d   = ovf;
        diff    = (exp_a >= exp_b) ? (exp_a - exp_b) : (exp_b - exp_a);
        shamt   = 32'(diff);
        // Shifting by more than MANTISSA-1 only replicates the sign, so clamp.
        if (shamt > MAX_SHIFT) begin
            shamt = MAX_SHIFT;
        end
        sum = {man_a[MANTISSA-1], man_a} + {man_b[MANTISSA-1], man_b};

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    man_a_d = bus.in_mantissa_A;
                    man_b_d = bus.in_mantissa_B;
                    exp_a_d = bus.in_exp_A;
                    exp_b_d = bus.in_exp_B;
                    ovf_d   = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                // Aligned operand overwrites its own register.
                if (exp_a >= exp_b) begin
                    man_b_d = $signed(man_b) >>> shamt;
                    exp_d   = exp_a;
                end else begin
                    man_a_d = $signed(man_a) >>> shamt;
                    exp_d   = exp_b;
                end
                state_d = ADD;
            end
            ADD: begin
                if (sum[MANTISSA] != sum[MANTISSA-1]) begin
                    if (&exp_r) begin
                        mant_d = sum[MANTISSA] ? {1'b1, {(MANTISSA-1){1'b0}}}
                                               : {1'b0, {(MANTISSA-1){1'b1}}};
                        ovf_d  = 1'b1;
                    end else begin
                        mant_d = sum[MANTISSA:1];
                        exp_d  = exp_r + 1'b1;
                    end
                end else begin
                    mant_d = sum[MANTISSA-1:0];
                end
                state_d = NORM;
            end
            NORM: begin
                if (mant == '0) begin
                    exp_d   = '0;
                    state_d = DONE;
                end else if ((mant[MANTISSA-1] == mant[MANTISSA-2]) && (exp_r != '0)) begin
                    mant_d = {mant[MANTISSA-2:0], 1'b0};
                    exp_d  = exp_r - 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready     = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.out_valid    = (state == DONE);
    assign bus.out_exp      = exp_r;
    assign bus.out_mantissa = mant;
    assign bus.out_ovf      = ovf;
endmodule

// File: tb/tb_fp_add_sequencer.sv
module tb_fp_add_sequencer;
    localparam int MW = 11;
    localparam int EW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_add_sequencer_if #(.MANTISSA(MW), .EXPONENT(EW)) bus ();

    fp_add_sequencer #(.MANTISSA(MW), .EXPONENT(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int m;
        int e;
        int ovf;
        int k;
        int acc;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ready_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random

    always @(posedge clk) cyc <= cyc + 1;

    // Spec vectors: operands and hand-computed results.
    int pin_ma[8]  = '{'h200, 'h200, 'h200, 'h200, 'h200, 'h200, 'h400, 'h001};
    int pin_ea[8]  = '{7,     5,     5,     5,     20,    31,    31,    3};
    int pin_mb[8]  = '{'h200, 'h200, 'h640, 'h600, 'h600, 'h200, 'h400, 'h000};
    int pin_eb[8]  = '{5,     5,     5,     5,     0,     31,    31,    0};
    int pin_rm[8]  = '{'h280, 'h200, 'h200, 'h000, 'h3FE, 'h3FF, 'h400, 'h008};
    int pin_re[8]  = '{7,     6,     2,     0,     19,    31,    31,    0};
    int pin_ro[8]  = '{0,     0,     0,     0,     0,     1,     1,     0};
    int pin_rk[8]  = '{0,     0,     3,     0,     1,     0,     0,     3};

    function automatic int sx(input int m);
        return (m >= (1 << (MW - 1))) ? m - (1 << MW) : m;
    endfunction

    // Value-level reference: align by floor division, add as integers,
    // then double until the mantissa uses its full signed range.
    function automatic void model(input int ma, input int ea, input int mb, input int eb,
                                  output int rm, output int re, output int ro, output int rk);
        int a, b, e, d, s;
        int maxp, minn, half;
        maxp = (1 << (MW - 1)) - 1;
        minn = -(1 << (MW - 1));
        half = 1 << (MW - 2);
        a = sx(ma);
        b = sx(mb);
        if (ea >= eb) begin
            d = ea - eb;
            e = ea;
            if (d > MW - 1) d = MW - 1;
            b = b >>> d;
        end else begin
            d = eb - ea;
            e = eb;
            if (d > MW - 1) d = MW - 1;
            a = a >>> d;
        end
        s  = a + b;
        ro = 0;
        if (s > maxp || s < minn) begin
            if (e == (1 << EW) - 1) begin
                s  = (s > 0) ? maxp : minn;
                ro = 1;
            end else begin
                s = s >>> 1;
                e = e + 1;
            end
        end
        rk = 0;
        if (s == 0) begin
            e = 0;
        end else begin
            while (e > 0 && s >= -half && s < half) begin
                s  = s * 2;
                e  = e - 1;
                rk = rk + 1;
            end
        end
        rm = s & ((1 << MW) - 1);
        re = e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Compare process: pins the model, then checks the DUT every cycle.
    initial begin
        int rm, re, ro, rk;
        bit prev_valid = 1'b0;
        bit prev_rst = 1'b0;
        txn_t t;
        for (int i = 0; i < 8; i++) begin
            model(pin_ma[i], pin_ea[i], pin_mb[i], pin_eb[i], rm, re, ro, rk);
            check($sformatf("model_mant[%0d]", i), 32'(rm), 32'(pin_rm[i]));
            check($sformatf("model_exp[%0d]", i), 32'(re), 32'(pin_re[i]));
            check($sformatf("model_ovf[%0d]", i), 32'(ro), 32'(pin_ro[i]));
            check($sformatf("model_k[%0d]", i), 32'(rk), 32'(pin_rk[i]));
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                prev_valid = 1'b0;
                prev_rst = 1'b1;
            end else begin
                if (prev_rst) begin
                    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
                    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
                    check("rst_busy", 32'(bus.busy), 32'd0);
                    check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
                    check("rst_out_exp", 32'(bus.out_exp), 32'd0);
                    check("rst_out_mantissa", 32'(bus.out_mantissa), 32'd0);
                end
                check("in_ready_vs_busy", 32'(bus.in_ready), 32'(!bus.busy));
                if (bus.out_valid) begin
                    check("pending_txn", 32'(q.size() > 0), 32'd1);
                    if (q.size() > 0) begin
                        t = q[0];
                        check("out_mantissa", 32'(bus.out_mantissa), 32'(t.m));
                        check("out_exp", 32'(bus.out_exp), 32'(t.e));
                        check("out_ovf", 32'(bus.out_ovf), 32'(t.ovf));
                        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                        if (!prev_valid) check("latency", 32'(cyc - t.acc + 1), 32'(4 + t.k));
                        if (bus.out_ready) void'(q.pop_front());
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    model(int'(bus.in_mantissa_A), int'(bus.in_exp_A),
                          int'(bus.in_mantissa_B), int'(bus.in_exp_B), rm, re, ro, rk);
                    t.m = rm; t.e = re; t.ovf = ro; t.k = rk; t.acc = cyc + 1;
                    q.push_back(t);
                end
                prev_valid = bus.out_valid;
                prev_rst = 1'b0;
            end
        end
    end

    // Sole driver of out_ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
    task automatic send(input int ma, input int ea, input int mb, input int eb);
        int waited = 0;
        bus.in_valid      = 1'b1;
        bus.in_mantissa_A = MW'(ma);
        bus.in_exp_A      = EW'(ea);
        bus.in_mantissa_B = MW'(mb);
        bus.in_exp_B      = EW'(eb);
        while (!bus.in_ready && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
            $fatal(1);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while ((q.size() != 0 || !bus.in_ready) && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        if (q.size() != 0 || !bus.in_ready) begin
            $display("FAIL drain_timeout: %0d results still pending", q.size());
            $fatal(1);
        end
    endtask

    initial begin
        int waited;
        bus.in_valid = 1'b0;
        bus.in_mantissa_A = '0;
        bus.in_exp_A = '0;
        bus.in_mantissa_B = '0;
        bus.in_exp_B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) send(pin_ma[i], pin_ea[i], pin_mb[i], pin_eb[i]);
        wait_drain();

        // Stalled consumer: result must hold while new operands are offered.
        ready_mode = 0;
        @(posedge clk); #1;
        send(pin_ma[0], pin_ea[0], pin_mb[0], pin_eb[0]);
        waited = 0;
        while (!bus.out_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.out_valid) begin
            $display("FAIL stall_wait: out_valid never rose");
            $fatal(1);
        end
        bus.in_valid = 1'b1;
        bus.in_mantissa_A = 11'h123;
        bus.in_exp_A = 5'd3;
        bus.in_mantissa_B = 11'h456;
        bus.in_exp_B = 5'd9;
        repeat (10) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        ready_mode = 1;
        wait_drain();

        // Reset while normalizing: transaction is dropped.
        send(pin_ma[2], pin_ea[2], pin_mb[2], pin_eb[2]);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        wait_drain();

        // Random traffic with a randomly stalling consumer.
        ready_mode = 2;
        for (int n = 0; n < 80; n++) begin
            int ma, ea, mb, eb;
            ma = $urandom_range(0, (1 << MW) - 1);
            mb = $urandom_range(0, (1 << MW) - 1);
            ea = $urandom_range(0, (1 << EW) - 1);
            case ($urandom_range(0, 3))
                0: eb = $urandom_range(0, (1 << EW) - 1);
                1: eb = ea;
                default: eb = (ea + $urandom_range(0, 3) > 31) ? 31 : ea + $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 4) == 0) ma = $urandom_range(0, 1) ? $urandom_range(0, 15)
                                                                     : (1 << MW) - $urandom_range(1, 16);
            if ($urandom_range(0, 7) == 0) begin
                ea = 31;
                eb = 31;
            end
            send(ma, ea, mb, eb);
        end
        ready_mode = 1;
        wait_drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
